// File: rtl/enxague_programavel_if.sv
// Control/status bundle of the programmable rinse sequencer.
// master drives the program request and pause; slave (the sequencer) drives the actuators and status.
interface enxague_programavel_if #(
    parameter int TEMPO_W  = 8,
    parameter int CICLOS_W = 3
);
    logic                start;
    logic                pausa;
    logic [TEMPO_W-1:0]  tempo_encher;
    logic [TEMPO_W-1:0]  tempo_agitar;
    logic [TEMPO_W-1:0]  tempo_drenar;
    logic [CICLOS_W-1:0] n_ciclos;
    logic                enxaguar_ativo;
    logic                valvula_agua;
    logic                motor;
    logic                bomba_dreno;
    logic [CICLOS_W-1:0] ciclo_atual;
    logic                fim;

    modport master (
        output start, pausa, tempo_encher, tempo_agitar, tempo_drenar, n_ciclos,
        input  enxaguar_ativo, valvula_agua, motor, bomba_dreno, ciclo_atual, fim
    );

    modport slave (
        input  start, pausa, tempo_encher, tempo_agitar, tempo_drenar, n_ciclos,
        output enxaguar_ativo, valvula_agua, motor, bomba_dreno, ciclo_atual, fim
    );
endinterface

// File: rtl/enxague_programavel.sv
// Rinse sequencer: fill/agitate/drain repeated n_ciclos times, then a one-cycle fim pulse.
// Program starts one edge after start; no flow control, pausa freezes state and gates actuators.
module enxague_programavel #(
    parameter int TEMPO_W  = 8,
    parameter int CICLOS_W = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    enxague_programavel_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, ENCHER, AGITAR, DRENAR, FIM} estado_t;

    typedef struct packed {
        logic [TEMPO_W-1:0]  encher;
        logic [TEMPO_W-1:0]  agitar;
        logic [TEMPO_W-1:0]  drenar;
        logic [CICLOS_W-1:0] n_ciclos;
    } cfg_t;

    estado_t             estado_q, estado_nxt;
    logic [TEMPO_W-1:0]  cnt_q, cnt_nxt;
    logic [CICLOS_W-1:0] ciclo_q, ciclo_nxt;
    cfg_t                cfg_q, cfg_nxt, cfg_in;
    estado_t             alvo;

    assign cfg_in = {bus.tempo_encher, bus.tempo_agitar, bus.tempo_drenar, bus.n_ciclos};

    // Returns FIM when every phase has zero length.
    function automatic estado_t primeira_fase(input cfg_t c);
        if (c.encher != '0)      return ENCHER;
        else if (c.agitar != '0) return AGITAR;
        else if (c.drenar != '0) return DRENAR;
        else                     return FIM;
    endfunction

    // IDLE is used as the "repetition finished" marker here.
    function automatic estado_t fase_seguinte(input estado_t e, input cfg_t c);
        estado_t r;
        r = IDLE;
        case (e)
            ENCHER: begin
                if (c.agitar != '0)      r = AGITAR;
                else if (c.drenar != '0) r = DRENAR;
            end
            AGITAR: begin
                if (c.drenar != '0) r = DRENAR;
            end
            default: r = IDLE;
        endcase
        return r;
    endfunction

    function automatic logic [TEMPO_W-1:0] duracao(input estado_t e, input cfg_t c);
        logic [TEMPO_W-1:0] r;
        case (e)
            ENCHER:  r = c.encher;
            AGITAR:  r = c.agitar;
            DRENAR:  r = c.drenar;
            default: r = '0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= IDLE;
            cnt_q    <= '0;
            ciclo_q  <= '0;
            cfg_q    <= '0;
        end else begin
            estado_q <= estado_nxt;
            cnt_q    <= cnt_nxt;
            ciclo_q  <= ciclo_nxt;
            cfg_q    <= cfg_nxt;
        end
    end

    always_comb begin
        estado_nxt = estado_q;
        cnt_nxt    = cnt_q;
        ciclo_nxt  = ciclo_q;
        cfg_nxt    = cfg_q;
        alvo       = IDLE;
        case (estado_q)
            IDLE: begin
                if (bus.start) begin
                    cfg_nxt = cfg_in;
                    alvo    = primeira_fase(cfg_in);
                    if (cfg_in.n_ciclos == '0 || alvo == FIM) begin
                        estado_nxt = FIM;
                        cnt_nxt    = '0;
                        ciclo_nxt  = '0;
                    end else begin
                        estado_nxt = alvo;
                        cnt_nxt    = duracao(alvo, cfg_in) - TEMPO_W'(1);
                        ciclo_nxt  = CICLOS_W'(1);
                    end
                end
            end
            ENCHER, AGITAR, DRENAR: begin
                if (!bus.pausa) begin
                    if (cnt_q != '0) begin
                        cnt_nxt = cnt_q - TEMPO_W'(1);
                    end else begin
                        alvo = fase_seguinte(estado_q, cfg_q);
                        if (alvo != IDLE) begin
                            estado_nxt = alvo;
                            cnt_nxt    = duracao(alvo, cfg_q) - TEMPO_W'(1);
                        end else if (ciclo_q < cfg_q.n_ciclos) begin
                            alvo       = primeira_fase(cfg_q);
                            estado_nxt = alvo;
                            cnt_nxt    = duracao(alvo, cfg_q) - TEMPO_W'(1);
                            ciclo_nxt  = ciclo_q + CICLOS_W'(1);
                        end else begin
                            estado_nxt = FIM;
                            cnt_nxt    = '0;
                            ciclo_nxt  = '0;
                        end
                    end
                end
            end
            FIM: begin
                estado_nxt = IDLE;
                ciclo_nxt  = '0;
            end
            default: begin
                estado_nxt = IDLE;
                cnt_nxt    = '0;
                ciclo_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        bus.enxaguar_ativo = (estado_q == ENCHER) || (estado_q == AGITAR) || (estado_q == DRENAR);
        bus.valvula_agua   = (estado_q == ENCHER) && !bus.pausa;
        bus.motor          = (estado_q == AGITAR) && !bus.pausa;
        bus.bomba_dreno    = (estado_q == DRENAR) && !bus.pausa;
        bus.ciclo_atual    = bus.enxaguar_ativo ? ciclo_q : '0;
        bus.fim            = (estado_q == FIM);
    end

endmodule

// File: tb/tb_enxague_programavel.sv
// Directed bench for the rinse sequencer: each program's per-cycle expected outputs are
// queued at launch and popped/compared every cycle after the start edge.
module tb_enxague_programavel;

    typedef struct packed {
        logic       ativo;
        logic       valve;
        logic       motor;
        logic       pump;
        logic [2:0] ciclo;
        logic       fim;
    } obs_t;

    logic clock;
    logic reset;
    int   checks;
    int   passed;
    obs_t sb[$];

    enxague_programavel_if #(.TEMPO_W(8), .CICLOS_W(3)) bus ();

    enxague_programavel #(.TEMPO_W(8), .CICLOS_W(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic obs_t observar();
        obs_t o;
        o.ativo = bus.enxaguar_ativo;
        o.valve = bus.valvula_agua;
        o.motor = bus.motor;
        o.pump  = bus.bomba_dreno;
        o.ciclo = bus.ciclo_atual;
        o.fim   = bus.fim;
        return o;
    endfunction

    function automatic obs_t mk(input bit at, input bit v, input bit m, input bit b,
                                input int c, input bit f);
        obs_t o;
        o.ativo = at;
        o.valve = v;
        o.motor = m;
        o.pump  = b;
        o.ciclo = 3'(c);
        o.fim   = f;
        return o;
    endfunction

    task automatic verificar(input string tag, input obs_t got, input obs_t exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %b expected %b (ativo,valve,motor,pump,ciclo[3],fim)",
                    tag, got, exp);
    endtask

    // Expected sequence of one program, one entry per cycle after its start edge.
    task automatic construir(input int e, input int a, input int d, input int n);
        if (!(n == 0 || (e == 0 && a == 0 && d == 0))) begin
            for (int r = 1; r <= n; r++) begin
                repeat (e) sb.push_back(mk(1, 1, 0, 0, r, 0));
                repeat (a) sb.push_back(mk(1, 0, 1, 0, r, 0));
                repeat (d) sb.push_back(mk(1, 0, 0, 1, r, 0));
            end
        end
        sb.push_back(mk(0, 0, 0, 0, 0, 1));
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
    endtask

    task automatic run(input string tag, input int e, input int a, input int d, input int n,
                       input int ps, input int pl, input int start_at, input bit twice,
                       input int reset_at);
        obs_t p;
        int   k;
        int   hold;
        sb.delete();
        hold = 0;
        construir(e, a, d, n);
        if (twice) begin
            hold = sb.size();
            construir(e, a, d, n);
        end
        if (pl > 0) begin
            p = sb[ps-1];
            p.valve = 1'b0;
            p.motor = 1'b0;
            p.pump  = 1'b0;
            repeat (pl) sb.insert(ps - 1, p);
        end
        if (reset_at > 0) begin
            while (sb.size() > reset_at) void'(sb.pop_back());
            repeat (2) sb.push_back(mk(0, 0, 0, 0, 0, 0));
        end

        @(negedge clock);
        reset            = 1'b0;
        bus.pausa        = 1'b0;
        bus.start        = 1'b1;
        bus.tempo_encher = 8'(e);
        bus.tempo_agitar = 8'(a);
        bus.tempo_drenar = 8'(d);
        bus.n_ciclos     = 3'(n);
        k = 0;
        while (sb.size() > 0 && k < 2000) begin
            @(posedge clock);
            k++;
            #1;
            bus.start = (k <= hold) || (k == start_at);
            bus.pausa = (k >= ps) && (k < ps + pl);
            reset     = (k == reset_at);
            if (k == 1 && !twice) begin
                // Inputs changing mid-program must not disturb the latched program.
                bus.tempo_encher = 8'($urandom_range(1, 255));
                bus.tempo_agitar = 8'($urandom_range(1, 255));
                bus.tempo_drenar = 8'($urandom_range(1, 255));
                bus.n_ciclos     = 3'($urandom_range(1, 7));
            end
            @(negedge clock);
            p = sb.pop_front();
            verificar($sformatf("%s cycle %0d", tag, k), observar(), p);
        end
        bus.start = 1'b0;
        bus.pausa = 1'b0;
        reset     = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        checks           = 0;
        passed           = 0;
        clock            = 1'b0;
        reset            = 1'b1;
        bus.start        = 1'b1;
        bus.pausa        = 1'b1;
        bus.tempo_encher = 8'd3;
        bus.tempo_agitar = 8'd3;
        bus.tempo_drenar = 8'd3;
        bus.n_ciclos     = 3'd2;

        repeat (2) @(posedge clock);
        repeat (3) begin
            @(negedge clock);
            verificar("reset state", observar(), mk(0, 0, 0, 0, 0, 0));
        end

        // First edge after reset release carries the start.
        run("basic 2/3/2 x1",       2, 3, 2, 1, 0, 0, 0, 1'b0, 0);
        run("1/1/1 x3",             1, 1, 1, 3, 0, 0, 0, 1'b0, 0);
        run("skip agitar x2",       2, 0, 1, 2, 0, 0, 0, 1'b0, 0);
        run("pause in encher",      4, 1, 1, 1, 3, 3, 0, 1'b0, 0);
        run("pause in drenar",      1, 1, 2, 2, 3, 2, 0, 1'b0, 0);
        run("n_ciclos zero",        5, 5, 5, 0, 0, 0, 0, 1'b0, 0);
        run("all durations zero",   0, 0, 0, 3, 0, 0, 0, 1'b0, 0);
        run("drain only x2",        0, 0, 1, 2, 0, 0, 0, 1'b0, 0);
        run("start while active",   3, 2, 2, 2, 0, 0, 5, 1'b0, 0);
        run("start held high",      1, 0, 1, 1, 0, 0, 0, 1'b1, 0);
        run("reset mid agitar c2",  2, 3, 2, 2, 0, 0, 0, 1'b0, 11);
        run("rerun after reset",    2, 3, 2, 2, 0, 0, 0, 1'b0, 0);
        run("max duration",       255, 0, 0, 1, 0, 0, 0, 1'b0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
